// File: rtl/branch_flush_if.sv
// Bundle between the EX stage / ALU and the branch flush controller.
// The EX side (master) presents the branch decode fields, the ALU zero flag
// and the stall; the controller (slave) returns the PC redirect, the pipeline
// register flushes and the optional statistics counters.
interface branch_flush_if #(
  parameter int ADDR_W = 32
);
  // EX-stage branch decode and ALU result
  logic              branch_valid;
  logic              branch_is_ne;
  logic              jump;
  logic              ZeroFlag;
  logic [ADDR_W-1:0] target_addr;
  logic              ex_stall;

  // Redirect / flush responses
  logic              pc_sel;
  logic [ADDR_W-1:0] pc_target;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              misalign_err;
  logic              busy;

  // Statistics (zero when the counters are not built)
  logic [31:0]       stat_branches;
  logic [31:0]       stat_taken;

  modport master (
    output branch_valid, branch_is_ne, jump, ZeroFlag, target_addr, ex_stall,
    input  pc_sel, pc_target, flush_if_id, flush_id_ex, misalign_err, busy,
    input  stat_branches, stat_taken
  );

  modport slave (
    input  branch_valid, branch_is_ne, jump, ZeroFlag, target_addr, ex_stall,
    output pc_sel, pc_target, flush_if_id, flush_id_ex, misalign_err, busy,
    output stat_branches, stat_taken
  );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Branch resolution and pipeline redirect sequencer (static predict-not-taken).
// A branch/jump in EX is resolved with the ALU zero flag; a taken, word-aligned
// target produces a one-cycle pc_sel pulse plus FLUSH_CYCLES non-stalled cycles
// of IF/ID and ID/EX flush. A taken but misaligned target only raises a
// one-cycle misalign_err and leaves the PC alone.
// Optional statistics counters are built when BRANCH_FLUSH_STATS_EN is defined;
// otherwise stat_branches/stat_taken are tied to zero.
module branch_flush_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2   // legal range 1..15
) (
  input logic           clk,
  input logic           rst_n,
  branch_flush_if.slave bus
);

  // Counter is loaded with FLUSH_CYCLES-1 and counts down to 0, so four bits
  // cover the whole legal range.
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              pc_sel_reg;
  logic [ADDR_W-1:0] pc_target_reg;
  logic              flush_reg;
  logic              misalign_reg;
  logic              busy_reg;

  logic evaluate;
  logic taken;
  logic aligned;
  logic redirect;
  logic misalign;

  // A branch is only looked at in IDLE with EX moving; anything presented
  // during FLUSH is the instruction being squashed and is ignored.
  assign evaluate = (state_reg == IDLE) && bus.branch_valid && !bus.ex_stall;
  assign taken    = bus.jump | (bus.ZeroFlag ^ bus.branch_is_ne);
  assign aligned  = (bus.target_addr[1:0] == 2'b00);
  assign redirect = evaluate && taken && aligned;
  assign misalign = evaluate && taken && !aligned;

  // Redirect FSM: all outputs are registered and cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      pc_sel_reg    <= 1'b0;
      pc_target_reg <= '0;
      flush_reg     <= 1'b0;
      misalign_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      // Both pulses last exactly one cycle regardless of stall.
      pc_sel_reg   <= 1'b0;
      misalign_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (redirect) begin
            state_reg     <= FLUSH;
            cnt_reg       <= CNT_LOAD;
            pc_sel_reg    <= 1'b1;
            pc_target_reg <= bus.target_addr;
            flush_reg     <= 1'b1;
            busy_reg      <= 1'b1;
          end else if (misalign) begin
            // pc_target deliberately keeps its previous value
            misalign_reg <= 1'b1;
          end
        end
        FLUSH: begin
          // Only non-stalled cycles count towards the flush length
          if (!bus.ex_stall) begin
            if (cnt_reg == 4'd0) begin
              state_reg <= IDLE;
              flush_reg <= 1'b0;
              busy_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          flush_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_sel       = pc_sel_reg;
  assign bus.pc_target    = pc_target_reg;
  assign bus.flush_if_id  = flush_reg;
  assign bus.flush_id_ex  = flush_reg;
  assign bus.misalign_err = misalign_reg;
  assign bus.busy         = busy_reg;

`ifdef BRANCH_FLUSH_STATS_EN
  // Index 0 counts evaluated branches, index 1 counts real redirects
  // (misaligned taken branches never redirect, so they are not counted).
  logic [1:0] stat_inc;
  assign stat_inc = {redirect, evaluate};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [31:0] count_reg;

      // Saturating event counter, cleared only by reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= 32'd0;
        end else if (stat_inc[gi] && (count_reg != 32'hFFFF_FFFF)) begin
          count_reg <= count_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign bus.stat_branches = g_stat[0].count_reg;
  assign bus.stat_taken    = g_stat[1].count_reg;
`else
  assign bus.stat_branches = 32'd0;
  assign bus.stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Scoreboard bench for branch_flush_ctrl: instance 0 uses FLUSH_CYCLES=2,
// instance 1 uses FLUSH_CYCLES=1. Stimulus pushes expected redirect /
// misalign events; a monitor per instance pops and compares on every
// pc_sel or misalign_err pulse and measures the flush length.
module tb_branch_flush_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_flush_if #(.ADDR_W(32)) bus0 ();
  branch_flush_if #(.ADDR_W(32)) bus1 ();

  branch_flush_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  branch_flush_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

`ifdef BRANCH_FLUSH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          inst;
    bit          is_mis;
    logic [31:0] addr;
    int          flen;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Per-instance views of the outputs so one monitor body serves both
  logic [1:0]  mon_sel, mon_fif, mon_fie, mon_mis, mon_busy;
  logic [31:0] mon_tgt [2];
  assign mon_sel  = {bus1.pc_sel,       bus0.pc_sel};
  assign mon_fif  = {bus1.flush_if_id,  bus0.flush_if_id};
  assign mon_fie  = {bus1.flush_id_ex,  bus0.flush_id_ex};
  assign mon_mis  = {bus1.misalign_err, bus0.misalign_err};
  assign mon_busy = {bus1.busy,         bus0.busy};
  assign mon_tgt[0] = bus0.pc_target;
  assign mon_tgt[1] = bus1.pc_target;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      bit active;
      int run_len;
      int exp_len;
      int last_sel;

      always @(negedge clk) begin : mon
        exp_t e;
        bit   ok;
        if (!rst_n) begin
          active  = 1'b0;
          run_len = 0;
        end else begin
          // Track the flush run started by the last pc_sel
          if (active && !mon_sel[gi]) begin
            if (mon_fif[gi]) begin
              run_len++;
              chk($sformatf("flush_sync%0d", gi), {30'd0, mon_fie[gi], mon_busy[gi]},
                  {30'd0, 2'b11});
            end else begin
              chk($sformatf("flush_len%0d", gi), run_len, exp_len);
              active = 1'b0;
            end
          end
          if (!active && !mon_sel[gi] && (mon_fif[gi] || mon_fie[gi] || mon_busy[gi])) begin
            chk($sformatf("stray_flush%0d", gi), {29'd0, mon_fif[gi], mon_fie[gi], mon_busy[gi]},
                32'd0);
          end
          if (mon_sel[gi] || mon_mis[gi]) begin
            ok = (exp_q.size() > 0) && (exp_q[0].inst == gi);
            chk($sformatf("event_expected%0d", gi), {31'd0, ok}, 32'd1);
            if (ok) begin
              e = exp_q.pop_front();
              chk($sformatf("misalign%0d", gi), {31'd0, mon_mis[gi]}, {31'd0, e.is_mis});
              chk($sformatf("pc_sel%0d", gi), {31'd0, mon_sel[gi]}, {31'd0, !e.is_mis});
              chk($sformatf("pc_target%0d", gi), mon_tgt[gi], e.addr);
              if (!e.is_mis) begin
                chk($sformatf("flush_on_sel%0d", gi),
                    {29'd0, mon_fif[gi], mon_fie[gi], mon_busy[gi]}, 32'd7);
                if (e.gap > 0) chk($sformatf("sel_gap%0d", gi), cyc - last_sel, e.gap);
                last_sel = cyc;
                active   = 1'b1;
                run_len  = 1;
                exp_len  = e.flen;
              end else begin
                chk($sformatf("no_flush_on_mis%0d", gi),
                    {29'd0, mon_fif[gi], mon_fie[gi], mon_busy[gi]}, 32'd0);
              end
            end
          end
        end
      end
    end
  endgenerate

  task automatic drive(int inst, bit bv, bit ne, bit jmp, bit z, logic [31:0] tgt, bit stall);
    if (inst == 0) begin
      bus0.branch_valid = bv; bus0.branch_is_ne = ne; bus0.jump = jmp;
      bus0.ZeroFlag = z; bus0.target_addr = tgt; bus0.ex_stall = stall;
    end else begin
      bus1.branch_valid = bv; bus1.branch_is_ne = ne; bus1.jump = jmp;
      bus1.ZeroFlag = z; bus1.target_addr = tgt; bus1.ex_stall = stall;
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int inst, bit mis, logic [31:0] a, int flen, int gap);
    exp_t e;
    e.inst = inst; e.is_mis = mis; e.addr = a; e.flen = flen; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // One-cycle branch presentation, then inputs return to idle
  task automatic issue(int inst, bit ne, bit jmp, bit z, logic [31:0] tgt);
    drive(inst, 1'b1, ne, jmp, z, tgt, 1'b0);
    step(1);
    drive(inst, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step(2);

    // Reset state
    chk("rst_pc_sel",    bus0.pc_sel, 0);
    chk("rst_pc_target", bus0.pc_target, 0);
    chk("rst_flush",     {30'd0, bus0.flush_if_id, bus0.flush_id_ex}, 0);
    chk("rst_misalign",  bus0.misalign_err, 0);
    chk("rst_busy",      bus0.busy, 0);
    chk("rst_stats",     bus0.stat_branches | bus0.stat_taken, 0);
    chk("rst_inst1",     {26'd0, bus1.pc_sel, bus1.flush_if_id, bus1.flush_id_ex,
                          bus1.misalign_err, bus1.busy, |bus1.pc_target}, 0);
    rst_n = 1'b1;
    step(1);

    // BEQ taken, aligned
    push(0, 0, 32'h100, 2, 0);
    issue(0, 0, 0, 1, 32'h100); step(4);
    // BNE with ZeroFlag=1: not taken
    issue(0, 1, 0, 1, 32'h180); step(3);
    // BNE with ZeroFlag=0: taken
    push(0, 0, 32'h140, 2, 0);
    issue(0, 1, 0, 0, 32'h140); step(4);
    // BEQ with ZeroFlag=0: not taken
    issue(0, 0, 0, 0, 32'h1C0); step(3);
    // Jump to misaligned target: pc_target keeps 0x140
    push(0, 1, 32'h140, 0, 0);
    issue(0, 0, 1, 0, 32'h102); step(3);
    // Jump overrides a not-taken BEQ condition
    push(0, 0, 32'h2C0, 2, 0);
    issue(0, 0, 1, 0, 32'h2C0); step(4);
    // Stall in IDLE holds evaluation; branch resolves once when stall drops
    push(0, 0, 32'h400, 2, 0);
    drive(0, 1, 0, 0, 1, 32'h400, 1); step(2);
    drive(0, 1, 0, 0, 1, 32'h400, 0); step(1);
    drive(0, 0, 0, 0, 0, 32'h0, 0);   step(4);
    // Taken branch, then 3 stalled cycles in FLUSH with a branch held valid
    push(0, 0, 32'h200, 5, 0);
    drive(0, 1, 0, 0, 1, 32'h200, 0); step(1);
    drive(0, 1, 0, 0, 1, 32'h300, 1); step(3);
    drive(0, 1, 0, 0, 1, 32'h300, 0); step(2);
    drive(0, 0, 0, 0, 0, 32'h0, 0);   step(4);

    chk("stat_branches_a", bus0.stat_branches, STATS ? 32'd8 : 32'd0);
    chk("stat_taken_a",    bus0.stat_taken,    STATS ? 32'd5 : 32'd0);

    // Reset asserted in the first FLUSH cycle
    issue(0, 0, 0, 1, 32'h500);
    chk("mid_pc_sel", bus0.pc_sel, 1);
    chk("mid_busy",   bus0.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pc_sel", bus0.pc_sel, 0);
    chk("arst_flush",  {30'd0, bus0.flush_if_id, bus0.flush_id_ex}, 0);
    chk("arst_busy",   bus0.busy, 0);
    chk("arst_target", bus0.pc_target, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1);
    push(0, 0, 32'h600, 2, 0);
    issue(0, 0, 0, 1, 32'h600); step(4);
    chk("stat_branches_b", bus0.stat_branches, STATS ? 32'd1 : 32'd0);
    chk("stat_taken_b",    bus0.stat_taken,    STATS ? 32'd1 : 32'd0);

    // FLUSH_CYCLES=1: taken branch every second cycle
    for (int k = 0; k < 4; k++) begin
      push(1, 0, 32'h1000 + 32'(16 * k), 1, (k == 0) ? 0 : 2);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 1, 32'h1000 + 32'(16 * k), 0); step(1);
      drive(1, 0, 0, 0, 0, 32'h0, 0);                   step(1);
    end
    step(4);
    chk("stat_branches_1", bus1.stat_branches, STATS ? 32'd4 : 32'd0);
    chk("stat_taken_1",    bus1.stat_taken,    STATS ? 32'd4 : 32'd0);

    step(3);
    chk("queue_empty", exp_q.size(), 0);
    chk("mon0_idle",   {31'd0, g_mon[0].active}, 0);
    chk("mon1_idle",   {31'd0, g_mon[1].active}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
